main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multi-cycle main control unit that issues the `ALUOp` class code consumed by `aluControl`, together with the datapath strobes, for each accepted RV32 instruction.

- Accepts one 7-bit opcode through a valid/ready handshake.
- Steps through decode, execute, memory and writeback states.
- Holds `ALUOp` stable long enough for the registered ALU-control decode to settle before the execute cycle.
- Counts retired instructions and flags unsupported opcodes.

## Interface

Parameters
- `CNT_W`, 16, width of the retired-instruction counter.

Ports
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: `opcode` is valid this cycle.
- `opcode` in 7: instruction bits [6:0].
- `instr_ready` out 1: FSM can accept an instruction.
- `ALUOp` out 2: class code to `aluControl`.
  - 00 load/store
  - 01 branch
  - 10 R-type
  - 11 I-arith
- `ALUSrc` out 1: ALU B operand select; 1 selects the immediate.
- `Branch` out 1: branch compare strobe.
- `MemRead` out 1: data memory read strobe.
- `MemWrite` out 1: data memory write strobe.
- `RegWrite` out 1: register file write strobe.
- `MemtoReg` out 1: writeback source select; 1 selects memory data.
- `done` out 1: one-cycle pulse in the final cycle of a legal instruction.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `instr_count` out `CNT_W`: count of retired legal instructions.

## Operation

Opcode classes (latched into `op_q` on acceptance)
- R-type 0110011
- I-arith 0010011
- load 0000011
- store 0100011
- branch 1100011
- any other opcode is illegal

States: IDLE, DECODE, EXEC, MEM, WB.

Transitions
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`, latch `opcode` into `op_q` and go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - Legal opcode: drive `ALUOp` for the class and go to EXEC.
  - Illegal opcode: assert `illegal` and go to IDLE.
- EXEC:
  - `ALUSrc`=1 for load, store and I-arith; 0 otherwise.
  - Branch: assert `Branch` and `done`, then go to IDLE.
  - R-type and I-arith: go to WB.
  - Load and store: go to MEM.
- MEM:
  - Load: assert `MemRead`, then go to WB.
  - Store: assert `MemWrite` and `done`, then go to IDLE.
- WB:
  - Assert `RegWrite` and `done`; assert `MemtoReg` only for load.
  - Then go to IDLE.

Output rules
- All outputs are Moore: decoded from the state register and `op_q` only.
- `ALUOp` is valid from DECODE through the final state of the instruction, and is 00 in IDLE.
- `ALUSrc` is held from EXEC through the final state.
- All other strobes are 0 outside the states listed above.
- `instr_count` increments by 1 on every clock edge where `done`=1.
  - It wraps modulo 2^`CNT_W`.
  - Illegal opcodes do not increment it.
- `opcode` is ignored while `instr_ready`=0; no queueing.

## Timing

- Reset (asynchronous) forces:
  - state = IDLE, `op_q` = 0, `instr_count` = 0
  - all strobes, `done` and `illegal` = 0
  - `ALUOp` = 00, `instr_ready` = 1
- Let acceptance be cycle 0 (IDLE, `instr_valid`=1). Then:
  - DECODE is cycle 1, EXEC is cycle 2.
  - Branch: `done` in cycle 2, 3 cycles total.
  - R-type and I-arith: WB in cycle 3, 4 cycles total.
  - Store: MEM in cycle 3, 4 cycles total.
  - Load: MEM in cycle 3, WB in cycle 4, 5 cycles total.
  - Illegal: `illegal` in cycle 1, 2 cycles total.
- Back-to-back: the next instruction can be accepted in the cycle after the final state, when IDLE is reached again.
- `ALUOp` is presented in DECODE (cycle 1). `aluControl` registers its output at the end of cycle 1, so the ALU control code is valid throughout EXEC.
- Reset asserted mid-instruction: immediate return to IDLE.
  - No `done` is issued and `instr_count` is cleared.
  - Strobes drop asynchronously.

## Test plan

- Reset, then R-type 0110011 at cycle 0:
  - `ALUOp`=10 in cycles 1–3.
  - `RegWrite`=1, `done`=1 in cycle 3.
  - `instr_count`=1 afterwards.
- Load 0000011:
  - `ALUOp`=00 and `ALUSrc`=1 in cycles 2–4.
  - `MemRead`=1 in cycle 3.
  - `RegWrite`=`MemtoReg`=1 and `done` in cycle 4.
- Store 0100011 followed immediately by branch 1100011:
  - `MemWrite`+`done` in cycle 3.
  - Branch accepted in cycle 4.
  - `ALUOp`=01 in cycles 5–6; `Branch`+`done` in cycle 6.
  - `instr_count`=2.
- Illegal opcode 1111111:
  - `illegal`=1 in cycle 1.
  - `instr_ready`=1 in cycle 2.
  - `instr_count` unchanged; no strobes asserted.
- Assert `reset` during MEM of a load:
  - Outputs return to reset values immediately.
  - `instr_count`=0, `instr_ready`=1.
- Retire 2^`CNT_W` I-arith instructions (`CNT_W`=4, 16 instructions):
  - `instr_count` wraps to 0.
  - `ALUOp`=11 in every DECODE, EXEC and WB cycle.

Source files
------------

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit: accepts one RV32 opcode per instruction and
// walks it through DECODE/EXEC/MEM/WB, issuing ALUOp and datapath strobes.
module main_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [6:0]       opcode,
  output logic             instr_ready,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_op_q;
  logic [CNT_W-1:0] r_count;

  logic       w_is_r;
  logic       w_is_i;
  logic       w_is_ld;
  logic       w_is_st;
  logic       w_is_br;
  logic       w_legal;
  logic       w_uses_imm;
  logic [1:0] w_class;

  assign w_is_r     = (r_op_q == OP_RTYPE);
  assign w_is_i     = (r_op_q == OP_IARITH);
  assign w_is_ld    = (r_op_q == OP_LOAD);
  assign w_is_st    = (r_op_q == OP_STORE);
  assign w_is_br    = (r_op_q == OP_BRANCH);
  assign w_legal    = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br;
  assign w_uses_imm = w_is_i | w_is_ld | w_is_st;

  always_comb begin
    w_class = 2'b00;
    if (w_is_br)     w_class = 2'b01;
    else if (w_is_r) w_class = 2'b10;
    else if (w_is_i) w_class = 2'b11;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op_q  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && instr_valid) r_op_q <= opcode;
      if (done) r_count <= r_count + 1'b1;
    end
  end

  // Outputs depend only on r_state and r_op_q, so the reset drops them at once.
  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    ALUOp       = 2'b00;
    ALUSrc      = 1'b0;
    Branch      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_legal) begin
          ALUOp  = w_class;
          w_next = S_EXEC;
        end else begin
          illegal = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_EXEC: begin
        ALUOp  = w_class;
        ALUSrc = w_uses_imm;
        if (w_is_br) begin
          Branch = 1'b1;
          done   = 1'b1;
          w_next = S_IDLE;
        end else if (w_is_r || w_is_i) begin
          w_next = S_WB;
        end else begin
          w_next = S_MEM;
        end
      end
      S_MEM: begin
        ALUOp  = w_class;
        ALUSrc = w_uses_imm;
        if (w_is_ld) begin
          MemRead = 1'b1;
          w_next  = S_WB;
        end else begin
          MemWrite = 1'b1;
          done     = 1'b1;
          w_next   = S_IDLE;
        end
      end
      S_WB: begin
        ALUOp    = w_class;
        ALUSrc   = w_uses_imm;
        RegWrite = 1'b1;
        MemtoReg = w_is_ld;
        done     = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign instr_count = r_count;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: expected per-cycle outputs are queued
// at issue time from the opcode-class timing rules; a monitor pops and compares.
module tb_main_control_fsm;

  localparam int CNT_W = 4;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       done;
    logic       illegal;
  } exp_t;

  logic             clock;
  logic             reset;
  logic             instr_valid;
  logic [6:0]       opcode;
  logic             instr_ready;
  logic [1:0]       ALUOp;
  logic             ALUSrc;
  logic             Branch;
  logic             MemRead;
  logic             MemWrite;
  logic             RegWrite;
  logic             MemtoReg;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  main_control_fsm #(.CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .instr_ready(instr_ready),
    .ALUOp      (ALUOp),
    .ALUSrc     (ALUSrc),
    .Branch     (Branch),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .done       (done),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       q[$];
  logic [CNT_W-1:0] m_count;
  bit         mon_en = 1'b0;
  int         busy_run = 0;
  logic [9:0] obs;

  assign obs = {ALUOp, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, done, illegal};

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: per-cycle output trace of one instruction, cycles 1..len-1 after acceptance.
  task automatic push_expected(input logic [6:0] op);
    int len;
    logic [1:0] cls;
    bit legal, ld, st, br, imm;
    exp_t e;
    legal = 1'b1; ld = 1'b0; st = 1'b0; br = 1'b0; imm = 1'b0;
    case (op)
      OP_R:    begin cls = 2'b10; len = 4; end
      OP_I:    begin cls = 2'b11; len = 4; imm = 1'b1; end
      OP_LD:   begin cls = 2'b00; len = 5; imm = 1'b1; ld = 1'b1; end
      OP_ST:   begin cls = 2'b00; len = 4; imm = 1'b1; st = 1'b1; end
      OP_BR:   begin cls = 2'b01; len = 3; br = 1'b1; end
      default: begin cls = 2'b00; len = 2; legal = 1'b0; end
    endcase
    for (int k = 1; k < len; k++) begin
      e = '0;
      if (!legal) begin
        e.illegal = 1'b1;
      end else begin
        e.aluop    = cls;
        e.alusrc   = imm && (k >= 2);
        e.branch   = br && (k == 2);
        e.memread  = ld && (k == 3);
        e.memwrite = st && (k == 3);
        e.done     = (k == len - 1);
        e.regwrite = (k == len - 1) && !br && !st;
        e.memtoreg = ld && (k == 4);
      end
      q.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    if (!mon_en) begin
      m_count = '0;
      q.delete();
      busy_run = 0;
    end else begin
      chk("instr_count", int'(instr_count), int'(m_count));
      if (!instr_ready) begin
        busy_run++;
        if (busy_run > 6) chk("busy_bound", busy_run, 6);
        if (q.size() == 0) begin
          chk("unexpected_busy", int'(obs), -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("cycle_outputs", int'(obs), int'(e));
          if (e.done) m_count = m_count + 1'b1;
        end
      end else begin
        busy_run = 0;
        chk("idle_outputs", int'(obs), 0);
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (!instr_ready) begin
      @(negedge clock); #1;
      guard++;
      if (guard > 20) begin
        $display("FAIL wait_idle: instr_ready stuck at %0d, expected 1", instr_ready);
        $fatal(1, "timeout");
      end
    end
  endtask

  // Waits for IDLE while throwing ignored noise at the inputs, then issues op for one cycle.
  task automatic issue(input logic [6:0] op, input int gap);
    int guard = 0;
    while (!instr_ready) begin
      instr_valid = 1'($urandom_range(0, 1));
      opcode      = 7'($urandom);
      @(negedge clock); #1;
      guard++;
      if (guard > 20) begin
        $display("FAIL issue_wait: instr_ready stuck at %0d, expected 1", instr_ready);
        $fatal(1, "timeout");
      end
    end
    instr_valid = 1'b0;
    repeat (gap) begin @(negedge clock); #1; end
    instr_valid = 1'b1;
    opcode      = op;
    push_expected(op);
    @(negedge clock); #1;
    instr_valid = 1'b0;
    opcode      = 7'($urandom);
  endtask

  logic [6:0] rop;
  logic [CNT_W-1:0] cnt_before;

  initial begin
    reset = 1'b0; instr_valid = 1'b0; opcode = '0;
    #2 reset = 1'b1;
    #1;
    chk("reset_outputs", int'(obs), 0);
    chk("reset_ready", int'(instr_ready), 1);
    chk("reset_count", int'(instr_count), 0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    issue(OP_R, 0);
    issue(OP_LD, 1);
    issue(OP_ST, 0);
    issue(OP_BR, 0);
    issue(7'b1111111, 0);
    wait_idle();
    chk("count_after_directed", int'(instr_count), 4);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: rop = OP_R;
        1: rop = OP_I;
        2: rop = OP_LD;
        3: rop = OP_ST;
        4: rop = OP_BR;
        5: rop = 7'b1111111;
        default: rop = 7'($urandom);
      endcase
      issue(rop, $urandom_range(0, 2));
    end

    wait_idle();
    @(negedge clock); #1;
    cnt_before = instr_count;
    for (int n = 0; n < 16; n++) issue(OP_I, 0);
    wait_idle();
    @(negedge clock); #1;
    chk("count_wrap", int'(instr_count), int'(cnt_before));

    issue(OP_BR, 0);
    wait_idle();
    @(negedge clock); #1;
    if (m_count == '0) begin
      issue(OP_BR, 0);
      wait_idle();
      @(negedge clock); #1;
    end
    issue(OP_LD, 0);
    repeat (2) @(negedge clock);
    #1;
    chk("memread_before_reset", int'(MemRead), 1);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset_outputs", int'(obs), 0);
    chk("midreset_ready", int'(instr_ready), 1);
    chk("midreset_count", int'(instr_count), 0);
    @(negedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    issue(OP_R, 0);
    issue(OP_ST, 0);
    wait_idle();
    @(negedge clock); #1;
    chk("count_after_reset", int'(instr_count), 2);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
